// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Request fields captured when an access is accepted
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } mem_req_t;

    // Reserved size or an address not aligned to the access size
    function automatic logic access_bad(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian byte-lane steering for stores and lane select plus extension for loads.
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic [3:0]  be_c,
    output logic [31:0] wd_c,
    output logic [31:0] ld_c
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Store: replicate the right-justified data so every candidate lane carries it
    always_comb begin
        be_c = 4'b0000;
        wd_c = wdata;
        case (size)
            SZ_BYTE: begin
                be_c = 4'b0001 << lo;
                wd_c = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c = lo[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{wdata[15:0]}};
            end
            SZ_WORD: be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    always_comb begin
        case (lo)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Load: move the selected lane to bit 0 and extend
    always_comb begin
        ld_c = rd_word;
        case (size)
            SZ_BYTE: ld_c = {{24{sgn & rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_c = {{16{sgn & rd_half[15]}}, rd_half};
            default: ld_c = rd_word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: word array with byte/half/word access, wait states,
// req/done handshake, pipeline stall and alignment/range error reporting.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WAIT   = 1,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall
);

    state_e              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    mem_req_t            rq;
    logic [ADDR_W-1:0]   idx_q;

    logic                accept_c;
    logic                illegal_c;
    logic [31:0]         rdata_d;
    logic                done_d;
    logic                err_d;
    logic                mem_we_c;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_word;
    logic [3:0]          be_c;
    logic [31:0]         wd_c;
    logic [31:0]         ld_c;

    assign accept_c  = (state == IDLE) && req;
    assign illegal_c = access_bad(size, addr[1:0]) || (addr[31:2] >= 30'(DEPTH));
    assign stall     = req && (state != DONE);
    assign rd_word   = mem[idx_q];

    mem_byte_lane u_lane (
        .size    (rq.size),
        .lo      (rq.lo),
        .sgn     (rq.sgn),
        .wdata   (rq.wdata),
        .rd_word (rd_word),
        .be_c    (be_c),
        .wd_c    (wd_c),
        .ld_c    (ld_c)
    );

    // State, counter, captured request and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            rq    <= '0;
            idx_q <= '0;
            rdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept_c) begin
                rq    <= '{we: we, size: size, sgn: sgn, lo: addr[1:0], wdata: wdata};
                idx_q <= addr[ADDR_W+1:2];
            end
            rdata <= rdata_d;
            done  <= done_d;
            err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal_c) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(WAIT);
                    end
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_d = cnt - CNT_W'(1);
                else           state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done/err/rdata are set on the edge entering DONE, so they line up with that state
    always_comb begin
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata;
        mem_we_c = 1'b0;
        case (state)
            IDLE: begin
                if (req && illegal_c) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done_d = 1'b1;
                    if (rq.we) mem_we_c = 1'b1;
                    else       rdata_d  = ld_c;
                end
            end
            default: ;
        endcase
    end

    // Array is intentionally unreset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem[idx_q][8*i +: 8] <= wd_c[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory controller for the MIPS pipeline's MEM stage. It replaces the fixed word-only, single-cycle data RAM hookup with:
- an internal word array of configurable depth;
- byte, halfword and word accesses with sign or zero extension;
- a programmable wait-state count;
- a request/done handshake with a stall output that freezes the pipeline;
- alignment and range error reporting.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words in the array; must be a power of two, 4 to 65536.
- WAIT, 1: extra wait-state cycles per access, 0 to 15.
- ADDR_W, $clog2(DEPTH): word-index width, derived, not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request; held high by the pipeline until done.
- we  in  1  1 = store, 0 = load; sampled with req in IDLE.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- sgn  in  1  1 = sign-extend loads, 0 = zero-extend; ignored for word and stores.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (bits 7:0 for byte, 15:0 for half).
- rdata  out  32  registered load result.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned, out-of-range or reserved size.
- stall  out  1  combinational: req && state != DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - With req = 1, latch we, size, sgn, addr and wdata.
  - If the access is illegal, go to DONE with err = 1. Illegal means: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; or addr[31:2] >= DEPTH.
  - Otherwise load cnt = WAIT and go to BUSY.
- BUSY:
  - With cnt != 0, decrement cnt.
  - With cnt = 0, perform the access on this edge and go to DONE.
  - A store writes only the addressed lanes.
  - A load registers the extended result into rdata.
- DONE: done = 1 for exactly one cycle, then return to IDLE unconditionally.
- Byte lanes are little-endian: byte k = bits 8k+7:8k, with k = addr[1:0]. A half at addr[1] = h occupies bits 16h+15:16h.
- Store steering:
  - Byte: wdata[7:0] is written to lane k.
  - Half: wdata[15:0] is written to lanes 2h and 2h+1.
  - Word: all lanes are written.
- Load extension: the selected byte or half is placed at rdata bit 0 and extended per sgn.
- On error: no array write; rdata is cleared to 0.
- rdata holds its value until the next load or error completion. Stores leave rdata unchanged.
- If req drops mid-transaction, the transaction still completes and done still pulses. The pipeline must not do this.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset values: state IDLE, cnt 0, rdata 0, done 0, err 0. stall follows req during reset.
- Reset asserted mid-transaction: return to IDLE. A store whose write edge has not yet occurred performs no write, and no done is produced.
- Legal access latency: the request is first seen in IDLE in cycle N; done is high in cycle N+WAIT+2. stall is high from N through N+WAIT+1 and low in the done cycle.
- Illegal access: done/err high in cycle N+1.
- Back-to-back: the cycle after DONE is IDLE, so a new req is accepted there at the earliest. Throughput is 1 access per WAIT+3 cycles.
- The write becomes visible to a load accepted in any later IDLE cycle; there is no bypass needed.

## Structure
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum (IDLE, BUSY, DONE);
  - the WAIT limit constant (15).
- One sub-module, mem_byte_lane (combinational), produces:
  - from size, addr[1:0] and wdata: a 4-bit lane-enable mask and 32-bit steered store data;
  - from a read word, size, addr[1:0] and sgn: the extended load result.
- The FSM, the counter and the array stay in data_mem_ctrl.

## Test plan
- Word store then load, WAIT = 1:
  - Stimulus: sw 0xDEADBEEF to addr 0x10; lw from 0x10.
  - Required: rdata = 0xDEADBEEF, err = 0.
  - Required: done exactly 3 cycles after each req accept; stall high for 3 cycles per access.
- Byte stores and extension:
  - Stimulus: sb 0x80 to 0x21, then lb and lbu from 0x21.
  - Required: rdata = 0xFFFFFF80, then 0x00000080.
  - Required: a word load of 0x20 shows only bits 15:8 changed.
- Halfword upper lane:
  - Stimulus: sh 0x8001 to 0x32, then lh from 0x32.
  - Required: rdata = 0xFFFF8001; bits 15:0 of word 0x30 unchanged.
- Errors:
  - Stimulus: lw 0x0D; sh 0x03; access at byte address 4*DEPTH; size = 11.
  - Required for each: done and err in the cycle after accept, rdata = 0, no array change.
- WAIT = 0 and WAIT = 15 builds:
  - Stimulus: the same word access in each build.
  - Required: done at N+2 and N+17 respectively.
  - Required: back-to-back requests are accepted in the cycle after DONE.
- Reset mid-store:
  - Stimulus: WAIT = 4; assert rst low in the second BUSY cycle of sw 0x12345678 to 0x40.
  - Required: outputs return to reset values immediately, no done, word 0x40 keeps its previous value.
